// File: rtl/sd_cmd_engine_if.sv
// rtl/sd_cmd_engine_if.sv - register bus bundle for the SD CMD engine
interface sd_cmd_engine_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD CMD-line engine: 48-bit command out, optional 48-bit response in, CRC7
module sd_crc7_step (
    input  logic [6:0] crc,
    input  logic       din,
    output logic [6:0] crc_next
);
    logic fb;
    assign fb       = din ^ crc[6];
    assign crc_next = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
endmodule

module sd_cmd_engine #(
    parameter int DEFAULT_DIV  = 124,
    parameter int RESP_TIMEOUT = 64,
    parameter int GAP_CYCLES   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    sd_cmd_engine_if.slave  bus,
    output logic            sd_clk,
    inout  wire             bidir_port
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;
    state_t state_q, state_d;

    localparam logic [7:0] TO_LAST  = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [31:0] arg_reg, resp_q;
    logic [7:0]  cmd_reg, clkdiv_reg, div_sh, div_cnt, div_lim, tick_cnt;
    logic [5:0]  resp_idx_q, bit_cnt;
    logic        done_q, timeout_q, crc_err_q, resp_exp, ign_crc;
    logic [39:0] tx_shift;
    logic [44:0] rx_shift;
    logic [6:0]  tx_crc, rx_crc, tx_crc_next, rx_crc_next;
    logic        cmd_oe, cmd_out, line_in, tx_bit;
    logic        busy, wr, start, div_wrap, rise_tick, fall_tick;

    assign bidir_port = cmd_oe ? cmd_out : 1'bz;
    assign line_in    = bidir_port;

    assign busy  = (state_q != S_IDLE);
    assign wr    = bus.chipselect && !bus.write_n;
    assign start = wr && (bus.address == 3'd1) && !busy;

    // The divisor is frozen for the whole transaction so CLKDIV writes cannot glitch SD_CLK mid-frame.
    assign div_lim   = busy ? div_sh : clkdiv_reg;
    assign div_wrap  = (div_cnt >= div_lim);
    assign rise_tick = div_wrap && !sd_clk;
    assign fall_tick = div_wrap && sd_clk;

    assign tx_bit = (bit_cnt < 6'd40) ? tx_shift[39] :
                    (bit_cnt < 6'd47) ? tx_crc[6] : 1'b1;

    sd_crc7_step u_tx_crc (.crc(tx_crc), .din(tx_shift[39]), .crc_next(tx_crc_next));
    sd_crc7_step u_rx_crc (.crc(rx_crc), .din(line_in),      .crc_next(rx_crc_next));

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SEND;
            S_SEND: if (fall_tick && bit_cnt == 6'd48) state_d = resp_exp ? S_WAIT : S_GAP;
            S_WAIT: if (rise_tick) begin
                if (!line_in)                 state_d = S_RECV;
                else if (tick_cnt == TO_LAST) state_d = S_GAP;
            end
            S_RECV: if (rise_tick && bit_cnt == 6'd47) state_d = S_GAP;
            S_GAP:  if (rise_tick && tick_cnt == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            sd_clk       <= 1'b0;
            div_cnt      <= '0;
            arg_reg      <= '0;
            cmd_reg      <= '0;
            clkdiv_reg   <= 8'(DEFAULT_DIV);
            div_sh       <= 8'(DEFAULT_DIV);
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            resp_q       <= '0;
            resp_idx_q   <= '0;
            resp_exp     <= 1'b0;
            ign_crc      <= 1'b0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            tx_crc       <= '0;
            rx_crc       <= '0;
            bit_cnt      <= '0;
            tick_cnt     <= '0;
            cmd_oe       <= 1'b0;
            cmd_out      <= 1'b1;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                sd_clk  <= ~sd_clk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (wr) begin
                case (bus.address)
                    3'd0: arg_reg <= bus.writedata;
                    3'd1: if (!busy) cmd_reg <= bus.writedata[7:0];
                    3'd2: begin done_q <= 1'b0; timeout_q <= 1'b0; crc_err_q <= 1'b0; end
                    3'd5: clkdiv_reg <= bus.writedata[7:0];
                    default: ;
                endcase
            end

            if (start) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                crc_err_q <= 1'b0;
                div_sh    <= clkdiv_reg;
                tx_shift  <= {2'b01, bus.writedata[5:0], arg_reg};
                tx_crc    <= '0;
                bit_cnt   <= '0;
                resp_exp  <= bus.writedata[6];
                ign_crc   <= bus.writedata[7];
            end

            // Status flag sets come after the STATUS-write clear so they win a same-cycle collision.
            case (state_q)
                S_SEND: if (fall_tick) begin
                    if (bit_cnt == 6'd48) begin
                        cmd_oe   <= 1'b0;
                        tick_cnt <= '0;
                    end else begin
                        cmd_oe  <= 1'b1;
                        cmd_out <= tx_bit;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt < 6'd40) begin
                            tx_shift <= {tx_shift[38:0], 1'b0};
                            tx_crc   <= tx_crc_next;
                        end else begin
                            tx_crc <= {tx_crc[5:0], 1'b0};
                        end
                    end
                end
                S_WAIT: if (rise_tick) begin
                    if (!line_in) begin
                        bit_cnt  <= 6'd1;
                        rx_crc   <= '0;
                        rx_shift <= '0;
                    end else if (tick_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        tick_cnt  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
                S_RECV: if (rise_tick) begin
                    rx_shift <= {rx_shift[43:0], line_in};
                    bit_cnt  <= bit_cnt + 6'd1;
                    if (bit_cnt < 6'd40) rx_crc <= rx_crc_next;
                    if (bit_cnt == 6'd47) begin
                        // rx_shift holds frame bits 45..1; line_in is the end bit.
                        resp_q     <= rx_shift[38:7];
                        resp_idx_q <= rx_shift[44:39];
                        crc_err_q  <= (!ign_crc && (rx_shift[6:0] != rx_crc)) || !line_in;
                        tick_cnt   <= '0;
                    end
                end
                S_GAP: if (rise_tick) begin
                    tick_cnt <= tick_cnt + 8'd1;
                    if (tick_cnt == GAP_LAST) done_q <= 1'b1;
                end
                default: ;
            endcase

            case (bus.address)
                3'd0:    bus.readdata <= arg_reg;
                3'd1:    bus.readdata <= {24'd0, cmd_reg};
                3'd2:    bus.readdata <= {28'd0, crc_err_q, timeout_q, done_q, busy};
                3'd3:    bus.readdata <= resp_q;
                3'd4:    bus.readdata <= {26'd0, resp_idx_q};
                3'd5:    bus.readdata <= {24'd0, clkdiv_reg};
                default: bus.readdata <= '0;
            endcase
        end
    end
endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Hardware SD-card CMD-line engine; replaces NIOS bit-banging of the SD CMD pin with an Avalon-MM slave that serializes a 48-bit command frame with CRC7.
- Also generates SD_CLK, waits for and captures a 48-bit response, and checks its CRC7.
- Sits between the Avalon fabric and the SD_CMD/SD_CLK pins. It is the stage directly downstream of the CPU's command-building software.

Parameters:
- DEFAULT_DIV, 124, reset value of CLKDIV. SD_CLK = clk / (2*(CLKDIV+1)); 124 gives 200 kHz from 50 MHz.
- RESP_TIMEOUT, 64, SD_CLK cycles to wait for a response start bit (NCR max).
- GAP_CYCLES, 8, SD_CLK cycles with CMD released after each transaction (NRC/NCC).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- address  in  3  register select
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  write data
- readdata  out  32  registered read data
- sd_clk  out  1  SD card clock
- bidir_port  inout  1  SD CMD line; driven only while transmitting, else Z

Behaviour:
- Reset: one clock, reset_n synchronous active-low.
  - Clears readdata, sd_clk, STATUS, ARG, RESP, RESP_IDX and state.
  - Sets state=IDLE, CLKDIV=DEFAULT_DIV, bidir_port=Z.
  - A reset asserted mid-transaction aborts immediately; the CMD line is released the next cycle.
- Registers:
  - 0 ARG: RW, 32 bits.
  - 1 CMD: write [5:0]=index, [6]=resp_expected, [7]=ignore_crc; reads last value.
  - 2 STATUS: RO bits [0]=busy, [1]=done, [2]=timeout, [3]=crc_err. Any write clears [3:1].
  - 3 RESP: response bits 39:8.
  - 4 RESP_IDX: response bits 45:40 in [5:0].
  - 5 CLKDIV: RW [7:0].
  - Other addresses read 0.
- readdata: updated every clk from the address mux, giving 1-cycle read latency. Unused bits are 0.
- Writes: write to CMD while busy=1 is ignored. Writes to ARG/CLKDIV while busy take effect for the next transaction only; they are shadowed at start.
- Starting a transaction: a CMD write when idle sets busy=1 and clears done/timeout/crc_err.
- Clock divider:
  - Counter runs 0..CLKDIV and toggles sd_clk at wrap. The rise tick fires when sd_clk goes 0->1; the fall tick fires on 1->0.
  - CLKDIV=0 gives SD_CLK = clk/2.
  - sd_clk runs continuously out of reset.
- Frame: {0,1,index[5:0],arg[31:0],crc7,1}, sent MSB first.
  - CRC7 uses polynomial x^7+x^3+1, initial 0, computed over the first 40 bits.
  - bidir_port changes only on the fall tick; sampling occurs on the rise tick.
- FSM:
  - IDLE -> SEND on accepted CMD write. The first bit is driven at the next fall tick.
  - SEND: 48 bits on 48 fall ticks. After bit 47, bidir_port goes Z at the next fall tick. Next state is WAIT if resp_expected, else GAP.
  - WAIT: count rise ticks. A sample of 0 means start bit; go to RECV.
    - Timeout occurs when the count reaches RESP_TIMEOUT without a start bit. Set timeout=1 and go to GAP.
  - RECV: shift 47 further bits on rise ticks.
    - Then load RESP and RESP_IDX.
    - crc_err=1 if ignore_crc=0 and the received CRC7 over bits 47..8 mismatches. It is also set if the end bit is 0.
    - Go to GAP.
  - GAP: GAP_CYCLES rise ticks with CMD Z, then set done=1, busy=0, go to IDLE.
- Simultaneous events:
  - A STATUS write in the same cycle the FSM sets done/error: the FSM set wins.
  - A CMD write in the same cycle busy falls is ignored, because busy is sampled pre-update.
- The response is captured even when crc_err=1. On timeout, RESP/RESP_IDX keep their previous values.

Test Plan:
- Reset: hold reset_n=0 for 2 clk -> STATUS=0, CLKDIV reads 124, bidir_port=Z, sd_clk=0. Release -> sd_clk period is 250 clk.
- CMD0: CLKDIV=0, ARG=0, CMD=0x00 -> line carries 0x40 00 00 00 00 95. After 48+8 SD_CLKs, STATUS=0x2 with no sampling window used.
- CMD8: ARG=0x000001AA, CMD=0x48 -> frame 0x48 00 00 01 AA 87. The model replies after 5 SD_CLKs with a bench-computed R7 (index 8, arg 0x1AA) -> RESP=0x000001AA, RESP_IDX=8, STATUS=0x2.
- CRC error: same as CMD8 but the model flips one CRC bit -> STATUS=0xA and RESP still loaded. Repeating with CMD[7]=1 -> STATUS=0x2.
- Timeout: CMD=0x51 with the line left high -> timeout set after exactly 64 rise ticks. STATUS=0x6 after the gap; a CMD write while busy has no effect.
- Abort: assert reset_n mid-SEND (bit 20) -> bidir_port=Z and STATUS=0 one clk later. A new CMD0 then completes normally.
